// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the 32-source CPU bus, with a GAP cycle between owners and a MAX_HOLD cap.
// Ports: clk, reset_n (async low), req[31:0] in; gnt[31:0] one-hot, sel[4:0] mux select, busy, timeout pulse out.
module bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] req,
  output logic [31:0] gnt,
  output logic [4:0]  sel,
  output logic        busy,
  output logic        timeout
);

  localparam logic [4:0] HOLD_MAX = 5'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  ptr, ptr_nxt;
  logic [4:0]  owner, owner_nxt;
  logic [4:0]  hold_cnt, hold_nxt;
  logic [31:0] gnt_nxt;
  logic [4:0]  sel_nxt;
  logic        busy_nxt;
  logic        timeout_nxt;

  logic        found;
  logic [4:0]  win;
  logic [4:0]  idx;

  // first requester at or after ptr, wrapping mod 32
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < 32; i++) begin
      idx = ptr + 5'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt;
    sel_nxt     = sel;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    unique case (state)
      GRANT: begin
        if (req[owner] && hold_cnt < HOLD_MAX) begin
          hold_nxt = hold_cnt + 5'd1;
        end else begin
          // still requesting here means the hold cap ended it
          state_nxt   = GAP;
          gnt_nxt     = '0;
          busy_nxt    = 1'b0;
          ptr_nxt     = owner + 5'd1;
          timeout_nxt = req[owner];
        end
      end
      IDLE, GAP: begin
        if (found) begin
          state_nxt = GRANT;
          owner_nxt = win;
          gnt_nxt   = 32'd1 << win;
          sel_nxt   = win;
          busy_nxt  = 1'b1;
          hold_nxt  = 5'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors for bus_arbiter with hand-computed expectations.
// Drives req/reset_n 1ns after each rising edge and samples outputs there too.
module tb_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic [31:0] req;
  logic [31:0] gnt;
  logic [4:0]  sel;
  logic        busy;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  bus_arbiter #(.MAX_HOLD(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag,
                           input logic [31:0] g,
                           input logic [4:0]  s,
                           input logic        b,
                           input logic        t);
    check({tag, ".gnt"}, gnt, g);
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1;
    chk_state("rst_async", 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    #2 reset_n = 1'b1;
    tick();
  endtask

  int rr [4] = '{3, 9, 3, 9};

  initial begin
    reset_n = 1'b0;
    req     = '0;
    #22 reset_n = 1'b1;
    tick();
    chk_state("reset", 32'h0, 5'd0, 1'b0, 1'b0);

    // no requests for 20 cycles
    for (int k = 0; k < 20; k++) begin
      tick();
      chk_state("idle", 32'h0, 5'd0, 1'b0, 1'b0);
    end

    // single requester, 3 granted cycles
    req[5] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_state("single", 32'h0000_0020, 5'd5, 1'b1, 1'b0);
    end
    req[5] = 1'b0;
    tick();
    chk_state("single_gap", 32'h0, 5'd5, 1'b0, 1'b0);
    tick();
    chk_state("single_idle", 32'h0, 5'd5, 1'b0, 1'b0);

    // round robin 3 / 9 after fresh reset (ptr=0)
    pulse_reset();
    req[3] = 1'b1;
    req[9] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk_state("rr_g1", 32'd1 << rr[n], 5'(rr[n]), 1'b1, 1'b0);
      tick();
      chk_state("rr_g2", 32'd1 << rr[n], 5'(rr[n]), 1'b1, 1'b0);
      req[rr[n]] = 1'b0;
      tick();
      chk_state("rr_gap", 32'h0, 5'(rr[n]), 1'b0, 1'b0);
      if (n < 2) req[rr[n]] = 1'b1;
    end
    tick();
    chk_state("rr_idle", 32'h0, 5'd9, 1'b0, 1'b0);

    // wrap-around: 31 released gives ptr=0
    req[31] = 1'b1;
    tick();
    chk_state("wrap31", 32'h8000_0000, 5'd31, 1'b1, 1'b0);
    req[31] = 1'b0;
    tick();
    chk_state("wrap_gap", 32'h0, 5'd31, 1'b0, 1'b0);
    req[30] = 1'b1;
    req[0]  = 1'b1;
    tick();
    chk_state("wrap0", 32'h0000_0001, 5'd0, 1'b1, 1'b0);
    req[0] = 1'b0;
    tick();
    chk_state("wrap_gap2", 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    chk_state("wrap30", 32'h4000_0000, 5'd30, 1'b1, 1'b0);
    req[30] = 1'b0;
    tick();
    tick();
    chk_state("wrap_idle", 32'h0, 5'd30, 1'b0, 1'b0);

    // hold timeout with MAX_HOLD=16
    req[7] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 16; k++) begin
        tick();
        chk_state("to_grant", 32'h0000_0080, 5'd7, 1'b1, 1'b0);
      end
      tick();
      chk_state("to_gap", 32'h0, 5'd7, 1'b0, 1'b1);
    end
    req[7] = 1'b0;
    tick();
    chk_state("to_idle", 32'h0, 5'd7, 1'b0, 1'b0);

    // async reset mid-grant of 12
    req[12] = 1'b1;
    tick();
    chk_state("g12", 32'h0000_1000, 5'd12, 1'b1, 1'b0);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk_state("rst_mid", 32'h0, 5'd0, 1'b0, 1'b0);
    req = '0;
    req[0]  = 1'b1;
    req[31] = 1'b1;
    tick();
    chk_state("rst_hold", 32'h0, 5'd0, 1'b0, 1'b0);
    #2 reset_n = 1'b1;
    tick();
    chk_state("rst_first", 32'h0000_0001, 5'd0, 1'b1, 1'b0);
    req[0] = 1'b0;
    tick();
    chk_state("rst_gap", 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    chk_state("rst_then31", 32'h8000_0000, 5'd31, 1'b1, 1'b0);
    req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
